// File: rtl/writeback_unit_pkg.sv
// Shared types and encodings for the RV32I writeback stage.
package tejas_wb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned SRC_W = 2;
  localparam int unsigned F3_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_WRITE    = 2'd3
  } wb_state_e;

  // Result source encodings; 2'b11 is reserved and handled as ALU.
  localparam logic [SRC_W-1:0] WB_ALU  = 2'b00;
  localparam logic [SRC_W-1:0] WB_LOAD = 2'b01;
  localparam logic [SRC_W-1:0] WB_PC4  = 2'b10;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Load context kept while the memory access is outstanding.
  typedef struct packed {
    logic             wen;
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  funct3;
    logic [1:0]       addr_lo;
  } wb_load_ctx_t;

  // True when the funct3 is a legal load and the address is naturally aligned.
  function automatic logic load_ok(input logic [F3_W-1:0] f3, input logic [1:0] addr_lo);
    logic ok;
    case (f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~addr_lo[0];
      F3_LW:         ok = (addr_lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Execute request, data-memory read and register-file write bundle.
// slave: the writeback unit; master: its environment (execute, memory, RF).
interface writeback_unit_if;
  import tejas_wb_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [SRC_W-1:0]      req_src;
  logic                  req_wen;
  logic [REG_W-1:0]      req_rd;
  logic [XLEN-1:0]       req_result;
  logic [XLEN-1:0]       req_pc;
  logic [F3_W-1:0]       req_funct3;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [XLEN-1:0]       mem_req_addr;
  logic                  mem_rsp_valid;
  logic [XLEN-1:0]       mem_rsp_data;

  logic                  rf_we;
  logic [REG_W-1:0]      rf_rd_addr;
  logic [XLEN-1:0]       rf_rd_data;
  logic                  wb_done;
  logic                  load_fault;

  modport slave (
    input  req_valid, req_src, req_wen, req_rd, req_result, req_pc, req_funct3,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, mem_req_valid, mem_req_addr,
    output rf_we, rf_rd_addr, rf_rd_data, wb_done, load_fault
  );

  modport master (
    output req_valid, req_src, req_wen, req_rd, req_result, req_pc, req_funct3,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  rf_we, rf_rd_addr, rf_rd_data, wb_done, load_fault
  );

endinterface

// File: rtl/writeback_unit_load_align.sv
// Combinational load lane select and sign/zero extension.
module load_align
  import tejas_wb_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [F3_W-1:0] funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lane;

  // Shift the addressed byte/half down to bit 0, then extend per funct3.
  always_comb begin
    lane   = word_i >> {addr_lo_i, 3'b000};
    data_o = lane;
    case (funct3_i)
      F3_LB:   data_o = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data_o = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  data_o = {24'h000000, lane[7:0]};
      F3_LHU:  data_o = {16'h0000, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: optional data-memory read, load alignment, single-cycle RF write.
module writeback_unit
  import tejas_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         reset_n,
  writeback_unit_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  wb_state_e        state_q, state_d;
  wb_load_ctx_t     ctx_q, ctx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic             rf_we_q, rf_we_d;
  logic [REG_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
  logic [XLEN-1:0]  rf_rd_data_q, rf_rd_data_d;
  logic             wb_done_q, wb_done_d;
  logic             load_fault_q, load_fault_d;
  logic [XLEN-1:0]  load_data;

  load_align u_load_align (
    .word_i    (bus.mem_rsp_data),
    .addr_lo_i (ctx_q.addr_lo),
    .funct3_i  (ctx_q.funct3),
    .data_o    (load_data)
  );

  // Next-state and registered-output logic; WRITE-cycle outputs are loaded on the edge entering WRITE.
  always_comb begin
    state_d         = state_q;
    ctx_d           = ctx_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    rf_we_d         = 1'b0;
    rf_rd_addr_d    = rf_rd_addr_q;
    rf_rd_data_d    = rf_rd_data_q;
    wb_done_d       = 1'b0;
    load_fault_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ctx_d.wen     = bus.req_wen;
          ctx_d.rd      = bus.req_rd;
          ctx_d.funct3  = bus.req_funct3;
          ctx_d.addr_lo = bus.req_result[1:0];
          if (bus.req_src == WB_LOAD) begin
            if (load_ok(bus.req_funct3, bus.req_result[1:0])) begin
              state_d         = ST_MEM_REQ;
              mem_req_valid_d = 1'b1;
              mem_req_addr_d  = {bus.req_result[XLEN-1:2], 2'b00};
            end else begin
              // Misaligned or illegal load: retire with fault, no memory access.
              state_d      = ST_WRITE;
              wb_done_d    = 1'b1;
              load_fault_d = 1'b1;
              rf_rd_addr_d = bus.req_rd;
              rf_rd_data_d = '0;
            end
          end else begin
            state_d      = ST_WRITE;
            wb_done_d    = 1'b1;
            rf_we_d      = bus.req_wen & (bus.req_rd != '0);
            rf_rd_addr_d = bus.req_rd;
            rf_rd_data_d = (bus.req_src == WB_PC4) ? (bus.req_pc + 32'd4) : bus.req_result;
          end
        end
      end

      ST_MEM_REQ: begin
        if (bus.mem_req_ready) begin
          state_d         = ST_MEM_WAIT;
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
        end
      end

      ST_MEM_WAIT: begin
        // A response in the limit cycle takes priority over the timeout.
        if (bus.mem_rsp_valid) begin
          state_d      = ST_WRITE;
          wb_done_d    = 1'b1;
          rf_we_d      = ctx_q.wen & (ctx_q.rd != '0);
          rf_rd_addr_d = ctx_q.rd;
          rf_rd_data_d = load_data;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
          state_d      = ST_WRITE;
          wb_done_d    = 1'b1;
          load_fault_d = 1'b1;
          rf_rd_addr_d = ctx_q.rd;
          rf_rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      ctx_q           <= '0;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      rf_we_q         <= 1'b0;
      rf_rd_addr_q    <= '0;
      rf_rd_data_q    <= '0;
      wb_done_q       <= 1'b0;
      load_fault_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      ctx_q           <= ctx_d;
      cnt_q           <= cnt_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      rf_we_q         <= rf_we_d;
      rf_rd_addr_q    <= rf_rd_addr_d;
      rf_rd_data_q    <= rf_rd_data_d;
      wb_done_q       <= wb_done_d;
      load_fault_q    <= load_fault_d;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.rf_we         = rf_we_q;
  assign bus.rf_rd_addr    = rf_rd_addr_q;
  assign bus.rf_rd_data    = rf_rd_data_q;
  assign bus.wb_done       = wb_done_q;
  assign bus.load_fault    = load_fault_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (TIMEOUT_CYCLES = 4).
module tb_writeback_unit;
  import tejas_wb_pkg::*;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  writeback_unit_if wb_if ();

  writeback_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (wb_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic [1:0] src, input logic wen, input logic [4:0] rd,
                       input logic [31:0] result, input logic [31:0] pc, input logic [2:0] f3);
    wb_if.req_src    = src;
    wb_if.req_wen    = wen;
    wb_if.req_rd     = rd;
    wb_if.req_result = result;
    wb_if.req_pc     = pc;
    wb_if.req_funct3 = f3;
    wb_if.req_valid  = 1'b1;
    step();
    wb_if.req_valid  = 1'b0;
  endtask

  // Full load: request held ready_delay cycles, response one cycle after the handshake.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input int ready_delay,
                          input logic [31:0] word, input logic [31:0] exp);
    logic [31:0] aligned;
    aligned = {addr[31:2], 2'b00};
    issue(WB_LOAD, 1'b1, rd, addr, 32'h0, f3);
    for (int i = 0; i < ready_delay; i++) begin
      check_eq({tag, "_reqv"}, 32'(wb_if.mem_req_valid), 32'd1);
      check_eq({tag, "_addr"}, wb_if.mem_req_addr, aligned);
      step();
    end
    check_eq({tag, "_reqv_hs"}, 32'(wb_if.mem_req_valid), 32'd1);
    check_eq({tag, "_addr_hs"}, wb_if.mem_req_addr, aligned);
    wb_if.mem_req_ready = 1'b1;
    step();
    wb_if.mem_req_ready = 1'b0;
    check_eq({tag, "_reqv_drop"}, 32'(wb_if.mem_req_valid), 32'd0);
    check_eq({tag, "_we_wait"}, 32'(wb_if.rf_we), 32'd0);
    wb_if.mem_rsp_valid = 1'b1;
    wb_if.mem_rsp_data  = word;
    step();
    wb_if.mem_rsp_valid = 1'b0;
    wb_if.mem_rsp_data  = 32'h0;
    check_eq({tag, "_we"}, 32'(wb_if.rf_we), (rd != 5'd0) ? 32'd1 : 32'd0);
    check_eq({tag, "_done"}, 32'(wb_if.wb_done), 32'd1);
    check_eq({tag, "_fault"}, 32'(wb_if.load_fault), 32'd0);
    check_eq({tag, "_rd"}, 32'(wb_if.rf_rd_addr), 32'(rd));
    check_eq({tag, "_data"}, wb_if.rf_rd_data, exp);
    step();
    check_eq({tag, "_we_off"}, 32'(wb_if.rf_we), 32'd0);
    check_eq({tag, "_ready"}, 32'(wb_if.req_ready), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n             = 1'b0;
    wb_if.req_valid     = 1'b0;
    wb_if.req_src       = WB_ALU;
    wb_if.req_wen       = 1'b0;
    wb_if.req_rd        = 5'd0;
    wb_if.req_result    = 32'h0;
    wb_if.req_pc        = 32'h0;
    wb_if.req_funct3    = 3'b000;
    wb_if.mem_req_ready = 1'b0;
    wb_if.mem_rsp_valid = 1'b0;
    wb_if.mem_rsp_data  = 32'h0;

    // Reset state
    step();
    step();
    check_eq("rst_ready", 32'(wb_if.req_ready), 32'd1);
    check_eq("rst_we", 32'(wb_if.rf_we), 32'd0);
    check_eq("rst_done", 32'(wb_if.wb_done), 32'd0);
    check_eq("rst_fault", 32'(wb_if.load_fault), 32'd0);
    check_eq("rst_reqv", 32'(wb_if.mem_req_valid), 32'd0);
    check_eq("rst_rd", 32'(wb_if.rf_rd_addr), 32'd0);
    check_eq("rst_data", wb_if.rf_rd_data, 32'h0);
    check_eq("rst_maddr", wb_if.mem_req_addr, 32'h0);
    reset_n = 1'b1;
    step();

    // ALU write, latency 1
    issue(WB_ALU, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 3'b000);
    check_eq("alu_we", 32'(wb_if.rf_we), 32'd1);
    check_eq("alu_rd", 32'(wb_if.rf_rd_addr), 32'd5);
    check_eq("alu_data", wb_if.rf_rd_data, 32'hDEADBEEF);
    check_eq("alu_done", 32'(wb_if.wb_done), 32'd1);
    check_eq("alu_busy", 32'(wb_if.req_ready), 32'd0);
    step();
    check_eq("alu_we_off", 32'(wb_if.rf_we), 32'd0);
    check_eq("alu_done_off", 32'(wb_if.wb_done), 32'd0);
    check_eq("alu_ready", 32'(wb_if.req_ready), 32'd1);
    check_eq("alu_hold", wb_if.rf_rd_data, 32'hDEADBEEF);

    // Reserved source behaves as ALU
    issue(2'b11, 1'b1, 5'd3, 32'h0BADF00D, 32'h40, 3'b000);
    check_eq("rsv_data", wb_if.rf_rd_data, 32'h0BADF00D);
    step();

    // PC+4 wrap, then rd = 0 suppression
    issue(WB_PC4, 1'b1, 5'd7, 32'h12345678, 32'hFFFFFFFC, 3'b000);
    check_eq("pc4_we", 32'(wb_if.rf_we), 32'd1);
    check_eq("pc4_wrap", wb_if.rf_rd_data, 32'h00000000);
    step();
    issue(WB_PC4, 1'b1, 5'd0, 32'h0, 32'h00000100, 3'b000);
    check_eq("rd0_we", 32'(wb_if.rf_we), 32'd0);
    check_eq("rd0_done", 32'(wb_if.wb_done), 32'd1);
    check_eq("rd0_data", wb_if.rf_rd_data, 32'h00000104);
    step();

    // Loads with aligned word 0x80F01234
    run_load("lb",  F3_LB,  32'h00001003, 5'd10, 2, 32'h80F01234, 32'hFFFFFF80);
    run_load("lbu", F3_LBU, 32'h00001003, 5'd11, 2, 32'h80F01234, 32'h00000080);
    run_load("lh",  F3_LH,  32'h00001002, 5'd12, 1, 32'h80F01234, 32'hFFFF80F0);
    run_load("lhu", F3_LHU, 32'h00001002, 5'd13, 0, 32'h80F01234, 32'h000080F0);
    run_load("lw",  F3_LW,  32'h00001000, 5'd14, 0, 32'h80F01234, 32'h80F01234);
    run_load("lb1", F3_LB,  32'h00001001, 5'd15, 0, 32'h80F01234, 32'h00000012);
    run_load("ld0", F3_LW,  32'h00002000, 5'd0,  0, 32'hCAFEF00D, 32'hCAFEF00D);

    // Misaligned LW faults immediately
    issue(WB_LOAD, 1'b1, 5'd6, 32'h00001002, 32'h0, F3_LW);
    check_eq("lwmis_reqv", 32'(wb_if.mem_req_valid), 32'd0);
    check_eq("lwmis_fault", 32'(wb_if.load_fault), 32'd1);
    check_eq("lwmis_done", 32'(wb_if.wb_done), 32'd1);
    check_eq("lwmis_we", 32'(wb_if.rf_we), 32'd0);
    step();
    check_eq("lwmis_fault_off", 32'(wb_if.load_fault), 32'd0);
    check_eq("lwmis_ready", 32'(wb_if.req_ready), 32'd1);

    // Illegal funct3 and odd halfword faults
    issue(WB_LOAD, 1'b1, 5'd6, 32'h00001000, 32'h0, 3'b011);
    check_eq("f3ill_fault", 32'(wb_if.load_fault), 32'd1);
    check_eq("f3ill_reqv", 32'(wb_if.mem_req_valid), 32'd0);
    step();
    issue(WB_LOAD, 1'b1, 5'd6, 32'h00001001, 32'h0, F3_LHU);
    check_eq("lhodd_fault", 32'(wb_if.load_fault), 32'd1);
    step();

    // Timeout with no response: fault in 5th cycle after entering MEM_WAIT
    issue(WB_LOAD, 1'b1, 5'd8, 32'h00003000, 32'h0, F3_LW);
    wb_if.mem_req_ready = 1'b1;
    step();
    wb_if.mem_req_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("to_wait%0d", i), 32'(wb_if.wb_done), 32'd0);
    end
    step();
    check_eq("to_fault", 32'(wb_if.load_fault), 32'd1);
    check_eq("to_done", 32'(wb_if.wb_done), 32'd1);
    check_eq("to_we", 32'(wb_if.rf_we), 32'd0);
    step();

    // Response in the limit cycle wins over the timeout
    issue(WB_LOAD, 1'b1, 5'd9, 32'h00003000, 32'h0, F3_LW);
    wb_if.mem_req_ready = 1'b1;
    step();
    wb_if.mem_req_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
    end
    wb_if.mem_rsp_valid = 1'b1;
    wb_if.mem_rsp_data  = 32'h13579BDF;
    step();
    wb_if.mem_rsp_valid = 1'b0;
    check_eq("lim_fault", 32'(wb_if.load_fault), 32'd0);
    check_eq("lim_we", 32'(wb_if.rf_we), 32'd1);
    check_eq("lim_data", wb_if.rf_rd_data, 32'h13579BDF);
    step();

    // Reset during MEM_WAIT, late response ignored
    issue(WB_LOAD, 1'b1, 5'd4, 32'h00004000, 32'h0, F3_LW);
    wb_if.mem_req_ready = 1'b1;
    step();
    wb_if.mem_req_ready = 1'b0;
    step();
    reset_n = 1'b0;
    #2;
    check_eq("arst_ready", 32'(wb_if.req_ready), 32'd1);
    check_eq("arst_data", wb_if.rf_rd_data, 32'h0);
    step();
    reset_n = 1'b1;
    wb_if.mem_rsp_valid = 1'b1;
    wb_if.mem_rsp_data  = 32'hFFFFFFFF;
    step();
    wb_if.mem_rsp_valid = 1'b0;
    check_eq("late_we", 32'(wb_if.rf_we), 32'd0);
    check_eq("late_done", 32'(wb_if.wb_done), 32'd0);
    check_eq("late_ready", 32'(wb_if.req_ready), 32'd1);
    issue(WB_ALU, 1'b1, 5'd9, 32'h12345678, 32'h0, 3'b000);
    check_eq("post_we", 32'(wb_if.rf_we), 32'd1);
    check_eq("post_rd", 32'(wb_if.rf_rd_addr), 32'd9);
    check_eq("post_data", wb_if.rf_rd_data, 32'h12345678);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
